// File: rtl/csr_uart_tx_pkg.sv
// Shared CSR map, modify encodings and status layout for the CSR-mapped UART transmitter.
package csr_uart_tx_pkg;

  localparam logic [11:0] CSR_UART  = 12'hBC0;
  localparam logic [11:0] CSR_LEDS  = 12'hBC1;
  localparam logic [11:0] CSR_TIMER = 12'hBC2;
  localparam logic [11:0] CSR_KHZ   = 12'hFC0;
  localparam logic [11:0] CSR_SIM   = 12'hBC8;

  typedef enum logic [2:0] {
    MOD_NONE  = 3'd0,
    MOD_WRITE = 3'd1,
    MOD_SET   = 3'd2,
    MOD_CLEAR = 3'd3
  } csr_mod_e;

  typedef struct packed {
    logic overflow;
    logic busy;
    logic full;
  } uart_status_t;

  // Status flags sit in bits 10:8 of the CSR read word; everything else reads zero.
  function automatic logic [31:0] pack_status(input uart_status_t s);
    return {21'b0, s, 8'b0};
  endfunction

endpackage

// File: rtl/csr_uart_tx_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; shared with the future UART receiver.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int LOG2  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2**LOG2];
  logic [LOG2:0]    wr_ptr;
  logic [LOG2:0]    rd_ptr;

  assign full  = (wr_ptr[LOG2] != rd_ptr[LOG2]) &&
                 (wr_ptr[LOG2-1:0] == rd_ptr[LOG2-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign dout  = mem[rd_ptr[LOG2-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[LOG2-1:0]] <= din;
  end

endmodule

// File: rtl/csr_uart_tx.sv
// CSR-mapped 8N1 UART transmitter: buffers written bytes in a FIFO and reports status on reads.
module csr_uart_tx
  import csr_uart_tx_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = CSR_UART,
  parameter int          CLK_KHZ   = 1000,
  parameter int          BAUD      = 115200,
  parameter int          FIFO_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  output logic        tx
);

  // Bit period in clocks; must be at least 2 for the counter below.
  localparam int                DIVISOR = (CLK_KHZ * 1000) / BAUD;
  localparam int                CNT_W   = $clog2(DIVISOR);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIVISOR - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  logic            q_hit;
  logic            q_rd;
  uart_status_t    status;
  uart_status_t    status_q;
  logic            overflow;
  logic            push;
  logic            ctl_write;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_dout;
  tx_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            unused_wdata;

  assign valid        = (addr == BASE_ADDR);
  assign unused_wdata = ^wdata[30:8];

  // Data phase belongs to the address registered one cycle earlier.
  assign push      = q_hit && (modify == MOD_WRITE) && !wdata[31];
  assign ctl_write = q_hit && (modify == MOD_WRITE) &&  wdata[31];
  assign pop       = (state == ST_IDLE) && !fifo_empty;

  assign status.full     = fifo_full;
  assign status.busy     = (state != ST_IDLE) || !fifo_empty;
  assign status.overflow = overflow;

  // Status is captured at the end of the read cycle, i.e. before a same-cycle push lands.
  assign rdata = q_rd ? pack_status(status_q) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_hit    <= 1'b0;
      q_rd     <= 1'b0;
      status_q <= '0;
      overflow <= 1'b0;
    end else begin
      q_hit    <= valid;
      q_rd     <= read && valid;
      status_q <= status;
      if (push && fifo_full) overflow <= 1'b1;
      else if (ctl_write)    overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // tx is registered alongside the state so the line level always matches the current state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift <= fifo_dout;
            cnt   <= CNT_MAX;
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt == '0) begin
            cnt     <= CNT_MAX;
            bit_idx <= '0;
            state   <= ST_DATA;
            tx      <= shift[0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == '0) begin
            cnt <= CNT_MAX;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == '0) state <= ST_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_uart_tx.sv
// Self-checking bench for csr_uart_tx: a line monitor decodes frames against a byte scoreboard.
module tb_csr_uart_tx;

  localparam int          DIV  = 4;
  localparam logic [11:0] BASE = 12'hBC0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic [2:0]  modify = 3'd0;
  logic [31:0] wdata = '0;
  logic [11:0] addr = '0;
  logic [31:0] rdata;
  logic        valid;
  logic        tx;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int dp0         = 0;
  int frames_done = 0;
  logic [7:0] sb_q[$];
  int         frame_starts[$];

  csr_uart_tx #(
    .BASE_ADDR (BASE),
    .CLK_KHZ   (1000),
    .BAUD      (250000),
    .FIFO_LOG2 (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .read   (read),
    .modify (modify),
    .wdata  (wdata),
    .addr   (addr),
    .rdata  (rdata),
    .valid  (valid),
    .tx     (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: on a falling line, pop the expected byte and check all 10*DIV cycles of the frame.
  initial begin : monitor
    logic [9:0] exp_frame;
    logic [7:0] exp_b;
    logic [7:0] got;
    bit         ok;
    bit         aborted;
    bit         unexpected;
    int         t0;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        t0 = cyc;
        frame_starts.push_back(t0);
        unexpected = (sb_q.size() == 0);
        exp_b = unexpected ? 8'h00 : sb_q.pop_front();
        if (unexpected) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: line went low at cycle %0d with nothing queued", t0);
        end
        exp_frame = {1'b1, exp_b, 1'b0};
        ok = 1'b1;
        aborted = 1'b0;
        got = '0;
        for (int k = 0; k < 10 * DIV && !aborted; k++) begin
          if (k > 0) @(negedge clk);
          if (rst) aborted = 1'b1;
          else begin
            if (tx !== exp_frame[k / DIV]) ok = 1'b0;
            if ((k % DIV) == DIV / 2 && k / DIV >= 1 && k / DIV <= 8) got[k / DIV - 1] = tx;
          end
        end
        if (!aborted) begin
          frames_done++;
          if (!unexpected) begin
            vectors++;
            if (!ok) begin
              miscompares++;
              $display("FAIL frame@%0d: decoded 0x%02h (waveform ok=%0b), expected 0x%02h with exact 8N1 timing",
                       t0, got, ok, exp_b);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream n consecutive byte writes (first, first+1, ...) with no idle cycles between data phases.
  task automatic write_stream(input int n, input logic [7:0] first, input bit expect_tx);
    logic [7:0] b;
    addr = BASE; read = 1'b0; modify = 3'd0;
    tick();
    for (int i = 0; i < n; i++) begin
      b = first + 8'(i);
      modify = 3'd1;
      wdata  = {24'h0, b};
      tick();
      if (i == 0) dp0 = cyc - 1;
      if (expect_tx) sb_q.push_back(b);
    end
    addr = '0; modify = 3'd0; wdata = '0;
  endtask

  task automatic csr_op(input logic [2:0] mod, input logic [31:0] data);
    addr = BASE; modify = 3'd0;
    tick();
    addr = '0; modify = mod; wdata = data;
    tick();
    modify = 3'd0; wdata = '0;
  endtask

  task automatic read_status(output logic [31:0] v);
    addr = BASE; read = 1'b1; modify = 3'd0;
    tick();
    read = 1'b0; addr = '0;
    v = rdata;
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames_done < n; i++) tick();
    vectors++;
    if (frames_done < n) begin
      miscompares++;
      $display("FAIL frame_timeout: %0d frames seen, %0d expected", frames_done, n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int bad;
    rst = 1'b1;
    repeat (3) tick();
    vectors++;
    if (tx !== 1'b1 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: tx=%b rdata=0x%08h, expected tx=1 rdata=0", tx, rdata);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1 || rdata !== 32'h0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_line: %0d of 20 idle cycles had tx!=1 or rdata!=0, expected 0", bad);
    end
    addr = 12'h000; #1;
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_miss: valid=%b for addr 0x000, expected 0", valid);
    end
    addr = BASE; #1;
    vectors++;
    if (valid !== 1'b1) begin
      miscompares++;
      $display("FAIL valid_hit: valid=%b for addr 0xBC0, expected 1", valid);
    end
    addr = '0;
    tick();
    read_status(v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_status: rdata=0x%08h, expected 0x00000000", v);
    end
  endtask

  task automatic test_single();
    logic [31:0] v;
    int base;
    int fd;
    base = frame_starts.size();
    fd = frames_done;
    write_stream(1, 8'h55, 1'b1);
    wait_frames(fd + 1, 100);
    vectors++;
    if (frame_starts.size() <= base || frame_starts[base] - dp0 != 2) begin
      miscompares++;
      $display("FAIL push_latency: start bit %0d cycles after data phase, expected 2",
               (frame_starts.size() > base) ? frame_starts[base] - dp0 : -1);
    end
    read_status(v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL single_done_status: rdata=0x%08h, expected 0x00000000", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int base;
    int fd;
    base = frame_starts.size();
    fd = frames_done;
    write_stream(2, 8'h41, 1'b1);
    read_status(v);
    vectors++;
    if (v !== 32'h200) begin
      miscompares++;
      $display("FAIL b2b_status: rdata=0x%08h, expected 0x00000200", v);
    end
    wait_frames(fd + 2, 200);
    vectors++;
    if (frame_starts.size() < base + 2 || frame_starts[base + 1] - frame_starts[base] != 10 * DIV + 1) begin
      miscompares++;
      $display("FAIL b2b_gap: frame start spacing %0d cycles, expected %0d",
               (frame_starts.size() >= base + 2) ? frame_starts[base + 1] - frame_starts[base] : -1,
               10 * DIV + 1);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int fd;
    fd = frames_done;
    write_stream(17, 8'h60, 1'b1);
    read_status(v);
    vectors++;
    if (v !== 32'h300) begin
      miscompares++;
      $display("FAIL full_no_drop: rdata=0x%08h, expected 0x00000300", v);
    end
    write_stream(1, 8'h99, 1'b0);
    read_status(v);
    vectors++;
    if (v !== 32'h700) begin
      miscompares++;
      $display("FAIL overflow_set: rdata=0x%08h, expected 0x00000700", v);
    end
    tick();
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rdata_one_cycle: rdata=0x%08h two cycles after read, expected 0", rdata);
    end
    csr_op(3'd1, 32'h8000_0000);
    read_status(v);
    vectors++;
    if (v !== 32'h300) begin
      miscompares++;
      $display("FAIL overflow_clear: rdata=0x%08h, expected 0x00000300", v);
    end
    wait_frames(fd + 17, 17 * (10 * DIV + 1) + 100);
    read_status(v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL drained_status: rdata=0x%08h, expected 0x00000000", v);
    end
  endtask

  task automatic test_ignored_ops();
    logic [31:0] v;
    int fd;
    int bad;
    fd = frames_done;
    csr_op(3'd2, 32'h0000_00FF);
    csr_op(3'd3, 32'h0000_00FF);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0 || frames_done != fd) begin
      miscompares++;
      $display("FAIL set_clear_ignored: %0d low cycles, %0d new frames, expected 0 and 0",
               bad, frames_done - fd);
    end
    read_status(v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL set_clear_status: rdata=0x%08h, expected 0x00000000", v);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    int fd;
    int bad;
    // 0xA5 has bit 3 = 0, so the line is low when reset hits.
    write_stream(3, 8'hA5, 1'b1);
    for (int i = 0; i < 40 && cyc < dp0 + 19; i++) tick();
    vectors++;
    if (tx !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_bit3: tx=%b in data bit 3 of 0xA5, expected 0", tx);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (tx !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_tx: tx=%b right after reset, expected 1", tx);
    end
    repeat (2) tick();
    sb_q.delete();
    fd = frames_done;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0 || frames_done != fd) begin
      miscompares++;
      $display("FAIL queue_flushed: %0d low cycles, %0d frames after reset, expected 0 and 0",
               bad, frames_done - fd);
    end
    read_status(v);
    vectors++;
    if (v !== 32'h0) begin
      miscompares++;
      $display("FAIL post_reset_status: rdata=0x%08h, expected 0x00000000", v);
    end
  endtask

  initial begin : main
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_ignored_ops();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
